antares_ifetch_unit: RTL
========================

# antares_ifetch_unit

Instruction-fetch unit: consumer of the program counter. It takes `if_pc`, runs a request/ready transaction on the instruction-memory bus, and registers the returned word for the ID stage. It drives `if_stall` back to the PC register so the PC holds while a fetch is outstanding. It also handles pipeline flushes and ID back-pressure.

## Interface
- `NOP_INSN`, default `32'h0000_0000`: instruction word presented when no valid fetch exists.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_pc` in 32: PC to fetch; held by the PC register while `if_stall`=1.
- `if_flush` in 1: redirect; the current or buffered fetch result is discarded.
- `id_stall` in 1: ID stage cannot accept a new instruction.
- `imem_addr` out 32: bus address.
- `imem_req` out 1: bus request.
- `imem_ready` in 1: bus response strobe, sampled at the rising edge.
- `imem_data` in 32: bus read data, valid when `imem_ready`=1.
- `imem_error` in 1: bus fault, qualified by `imem_ready`.
- `if_stall` out 1: to the PC register; hold the PC.
- `if_instruction` out 32: registered instruction to ID.
- `if_inst_valid` out 1: `if_instruction` is a real fetch result.
- `if_bus_error` out 1: the fetch in `if_instruction` faulted on the bus.
- `if_addr_error` out 1: the fetch in `if_instruction` had a misaligned PC (see Configuration).

## Operation
- **Bus rule:** once `imem_req`=1, `imem_req` and `imem_addr` stay stable until the edge where `imem_ready`=1. No second request is outstanding at any time.
- **State register:** `addr_q`, 32 bits. `imem_addr` = `if_pc` in FETCH, `addr_q` in DRAIN. `addr_q` <= `if_pc` every FETCH cycle.
- **IDLE** (entered on reset, lasts one cycle): `imem_req`=0, `if_stall`=1; next state FETCH.
- **FETCH:** `imem_req`=1.
  - `imem_ready`=0, `if_flush`=0: `if_stall`=1; stay in FETCH.
  - `imem_ready`=0, `if_flush`=1: `if_stall`=0, so the PC loads the redirect target; `if_inst_valid`<=0; go to DRAIN.
  - `imem_ready`=1, `if_flush`=1: discard the data; `if_instruction`<=`NOP_INSN`, `if_inst_valid`<=0, `if_stall`=0; stay in FETCH.
  - `imem_ready`=1, `id_stall`=0: `if_instruction`<=`imem_data`, `if_inst_valid`<=1, `if_bus_error`<=`imem_error`, `if_stall`=0; stay in FETCH.
  - `imem_ready`=1, `id_stall`=1: `buf`<=`imem_data`, `buf_err`<=`imem_error`; outputs hold; `if_stall`=1; go to HOLD.
- **HOLD:** `imem_req`=0, `if_stall`=1.
  - `if_flush`=1: drop `buf`; `if_inst_valid`<=0; go to FETCH.
  - Else `id_stall`=0: `if_instruction`<=`buf`, `if_inst_valid`<=1, `if_bus_error`<=`buf_err`; go to FETCH.
  - Else: stay in HOLD.
- **DRAIN:** `imem_req`=1 with `addr_q`; `if_stall`=1. On `imem_ready` the response is discarded and the next state is FETCH. `if_flush` in DRAIN has no further effect.
- **Error responses:** `if_instruction`=`NOP_INSN`, `if_inst_valid`=1, `if_bus_error`=1. The exception travels down the pipeline.
- **ID back-pressure:** `id_stall`=1 outside a ready cycle leaves the registered outputs unchanged. It never cancels an outstanding request.
- **Flush priority:** `if_flush` has priority over `id_stall`.

## Timing
- **Reset values:**
  - state IDLE.
  - `if_instruction`=`NOP_INSN`.
  - `if_inst_valid`, `if_bus_error`, `if_addr_error` = 0.
  - `addr_q`, `buf` = 0.
  - `imem_req`=0, `if_stall`=1.
- **Reset mid-transaction:** the request is abandoned immediately. The bus must tolerate `imem_req` dropping.
- **Latency:** zero-wait memory (`imem_ready` in the first `imem_req` cycle) delivers one instruction per clock. N wait cycles add N cycles of `if_stall`.
- **Output registers:** `if_instruction`, `if_inst_valid` and the error flags update one edge after the accepting `imem_ready`.
- **Combinational outputs:** `if_stall`, `imem_req` and `imem_addr` are combinational from state and inputs. There is no combinational path from `imem_data` to any output.

## Configuration
- **`ANTARES_IFETCH_ALIGN_CHECK_EN` defined:** in FETCH with `if_pc[1:0]`≠0, `imem_req`=0 and no bus transaction occurs. The fetch completes that cycle as an error:
  - `if_instruction`<=`NOP_INSN`, `if_inst_valid`<=1, `if_addr_error`<=1, `if_stall`=0.
  - The same `id_stall`/HOLD rules apply, with `buf_err` recording the address error.
- **Undefined:** `if_pc` goes to the bus unchanged, and `if_addr_error` is tied to 0.

## Test plan
- **Zero-wait fetch:** release reset, `if_pc`=`32'hBFC0_0000`, `imem_ready` always 1, data `32'h2408_0001`. Expect `if_stall`=1 for the IDLE cycle only, then `if_instruction`=`32'h2408_0001` with `if_inst_valid`=1 one edge after the first ready, with no further stalls.
- **Wait states:** `imem_ready` delayed 3 cycles. Expect `if_stall`=1 for exactly 3 cycles and `imem_addr` stable throughout, then valid data.
- **Flush while waiting:** assert `if_flush` in wait cycle 1. Expect `if_stall`=0 that cycle, then DRAIN keeps `imem_addr`=old PC. The old response is dropped (`if_inst_valid`=0), and the next fetch uses the new PC `32'h8000_0180`.
- **ID stall at ready:** `id_stall`=1 when data `32'hDEAD_BEEF` returns. Expect the outputs to hold, `imem_req`=0 and `if_stall`=1 until `id_stall` falls, then `if_instruction`=`32'hDEAD_BEEF`. Repeat with `if_flush` during HOLD: expect the buffer to be dropped and `if_inst_valid`=0.
- **Errors:** `imem_error`=1 with ready gives `if_bus_error`=1 and `NOP_INSN`. With the macro defined, `if_pc`=`32'h0000_0002` gives no request and `if_addr_error`=1. Asserting `rst`=0 mid-wait forces all outputs to their reset values asynchronously.

Source files
------------

// File: rtl/antares_ifetch_unit.sv
// antares_ifetch_unit
//   Instruction-fetch stage. Fetches the word at if_pc over a request/ready
//   instruction-memory bus and registers it for the ID stage. It holds the PC
//   while a fetch is outstanding. It also handles redirects (if_flush) and
//   back-pressure from ID (id_stall).
//
//   Optional feature macro: ANTARES_IFETCH_ALIGN_CHECK_EN
//     defined   : a misaligned if_pc completes without a bus request and is
//                 reported through if_addr_error.
//     undefined : if_pc goes to the bus unchanged; if_addr_error stays 0.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous reset, active low
//   if_pc          in   PC to fetch (held by the PC register while if_stall=1)
//   if_flush       in   redirect: discard the current/buffered fetch result
//   id_stall       in   ID cannot accept a new instruction
//   imem_addr      out  bus address
//   imem_req       out  bus request
//   imem_ready     in   bus response strobe
//   imem_data      in   bus read data (valid with imem_ready)
//   imem_error     in   bus fault (qualified by imem_ready)
//   if_stall       out  hold the PC
//   if_instruction out  registered instruction to ID
//   if_inst_valid  out  if_instruction is a real fetch result
//   if_bus_error   out  fetch in if_instruction faulted on the bus
//   if_addr_error  out  fetch in if_instruction had a misaligned PC
module antares_ifetch_unit #(
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_flush,
  input  logic        id_stall,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        imem_error,
  output logic        if_stall,
  output logic [31:0] if_instruction,
  output logic        if_inst_valid,
  output logic        if_bus_error,
  output logic        if_addr_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] buf_data_reg, buf_data_next;
  logic        buf_bus_err_reg, buf_bus_err_next;
  logic        buf_addr_err_reg, buf_addr_err_next;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;
  logic        bus_err_reg, bus_err_next;
  logic        addr_err_reg, addr_err_next;

  logic        misaligned;
  logic        fetch_done;
  logic [31:0] fetch_word;
  logic        fetch_bus_err;

`ifdef ANTARES_IFETCH_ALIGN_CHECK_EN
  assign misaligned = (if_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned PC "completes" immediately as an error, without a bus cycle.
  assign fetch_done    = imem_ready | misaligned;
  // Faulting fetches deliver the NOP word so the exception travels with a bubble.
  assign fetch_word    = (imem_error | misaligned) ? NOP_INSN : imem_data;
  assign fetch_bus_err = imem_error & ~misaligned;

  // DRAIN keeps the abandoned address on the bus until its response arrives,
  // while the PC register already holds the redirect target.
  assign imem_addr = (state_reg == DRAIN) ? addr_reg : if_pc;

  always_comb begin
    state_next        = state_reg;
    imem_req          = 1'b0;
    if_stall          = 1'b1;
    instr_next        = instr_reg;
    valid_next        = valid_reg;
    bus_err_next      = bus_err_reg;
    addr_err_next     = addr_err_reg;
    buf_data_next     = buf_data_reg;
    buf_bus_err_next  = buf_bus_err_reg;
    buf_addr_err_next = buf_addr_err_reg;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        imem_req = ~misaligned;
        if (if_flush) begin
          // Release the PC so it loads the redirect target this cycle.
          if_stall   = 1'b0;
          valid_next = 1'b0;
          if (fetch_done) begin
            instr_next    = NOP_INSN;
            bus_err_next  = 1'b0;
            addr_err_next = 1'b0;
          end else begin
            state_next = DRAIN;
          end
        end else if (fetch_done) begin
          if (!id_stall) begin
            if_stall      = 1'b0;
            instr_next    = fetch_word;
            valid_next    = 1'b1;
            bus_err_next  = fetch_bus_err;
            addr_err_next = misaligned;
          end else begin
            buf_data_next     = fetch_word;
            buf_bus_err_next  = fetch_bus_err;
            buf_addr_err_next = misaligned;
            state_next        = HOLD;
          end
        end
      end

      HOLD: begin
        if (if_flush) begin
          valid_next = 1'b0;
          state_next = FETCH;
        end else if (!id_stall) begin
          instr_next    = buf_data_reg;
          valid_next    = 1'b1;
          bus_err_next  = buf_bus_err_reg;
          addr_err_next = buf_addr_err_reg;
          state_next    = FETCH;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_next = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      addr_reg         <= 32'h0000_0000;
      buf_data_reg     <= 32'h0000_0000;
      buf_bus_err_reg  <= 1'b0;
      buf_addr_err_reg <= 1'b0;
      instr_reg        <= NOP_INSN;
      valid_reg        <= 1'b0;
      bus_err_reg      <= 1'b0;
      addr_err_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      if (state_reg == FETCH) begin
        addr_reg <= if_pc;
      end
      buf_data_reg     <= buf_data_next;
      buf_bus_err_reg  <= buf_bus_err_next;
      buf_addr_err_reg <= buf_addr_err_next;
      instr_reg        <= instr_next;
      valid_reg        <= valid_next;
      bus_err_reg      <= bus_err_next;
      addr_err_reg     <= addr_err_next;
    end
  end

  assign if_instruction = instr_reg;
  assign if_inst_valid  = valid_reg;
  assign if_bus_error   = bus_err_reg;
  assign if_addr_error  = addr_err_reg;

endmodule
